// File: rtl/screen_sched_ctrl.sv
// Frame-synchronous screen scheduler: picks start/play/game-over pixels and switches only on vsync falling edges.
// Optional black frames between screens are built when SCREEN_BLANK_EN is defined.
module screen_sched_ctrl #(
  parameter int BLANK_FRAMES = 2,
  parameter int RGB_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             ready_in,
  input  logic             start_req,
  input  logic             play_req,
  input  logic             over_req,
  input  logic [RGB_W-1:0] start_rgb,
  input  logic [RGB_W-1:0] play_rgb,
  input  logic [RGB_W-1:0] over_rgb,
  output logic [RGB_W-1:0] rgb_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [1:0]       screen_id,
  output logic             switching
);

`ifdef SCREEN_BLANK_EN
  typedef enum logic [1:0] {SHOW, WAIT_FB, BLANK} state_t;
  localparam logic [3:0] BLANK_INIT = 4'(BLANK_FRAMES - 1);
  logic [3:0] blank_cnt_q;
`else
  typedef enum logic [1:0] {SHOW, WAIT_FB} state_t;
`endif

  state_t           state_q;
  logic [1:0]       screen_q;
  logic [1:0]       pend_q;
  logic             vs_q;
  logic             switching_q;
  logic [RGB_W-1:0] rgb_q;
  logic             hs_out_q;
  logic             vs_out_q;

  logic             fb;
  logic             req_vld;
  logic [1:0]       tgt;
  logic             black;
  logic [RGB_W-1:0] sel_rgb;

  assign fb = vs_q & ~vsync_in;

  // Simultaneous requests resolve as over > play > start.
  always_comb begin
    req_vld = start_req | play_req | over_req;
    tgt     = 2'd0;
    if (over_req)      tgt = 2'd2;
    else if (play_req) tgt = 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SHOW;
      screen_q    <= 2'd0;
      pend_q      <= 2'd0;
      vs_q        <= 1'b1;
      switching_q <= 1'b0;
`ifdef SCREEN_BLANK_EN
      blank_cnt_q <= 4'd0;
`endif
    end else begin
      vs_q <= vsync_in;
      case (state_q)
        SHOW: begin
          if (req_vld && (tgt != screen_q)) begin
            pend_q      <= tgt;
            state_q     <= WAIT_FB;
            switching_q <= 1'b1;
          end
        end
        WAIT_FB: begin
          if (req_vld) pend_q <= tgt;
          if (fb) begin
`ifdef SCREEN_BLANK_EN
            state_q     <= BLANK;
            blank_cnt_q <= BLANK_INIT;
`else
            state_q     <= SHOW;
            screen_q    <= pend_q;
            switching_q <= 1'b0;
`endif
          end
        end
`ifdef SCREEN_BLANK_EN
        BLANK: begin
          if (req_vld) pend_q <= tgt;
          if (fb) begin
            if (blank_cnt_q == 4'd0) begin
              screen_q    <= pend_q;
              state_q     <= SHOW;
              switching_q <= 1'b0;
            end else begin
              blank_cnt_q <= blank_cnt_q - 4'd1;
            end
          end
        end
`endif
        default: begin
          state_q     <= SHOW;
          switching_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCREEN_BLANK_EN
  assign black = (state_q == BLANK);
`else
  assign black = 1'b0;
`endif

  always_comb begin
    case (screen_q)
      2'd0:    sel_rgb = start_rgb;
      2'd1:    sel_rgb = play_rgb;
      default: sel_rgb = over_rgb;
    endcase
  end

  // One register stage keeps pixel and syncs mutually aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q    <= '0;
      hs_out_q <= 1'b1;
      vs_out_q <= 1'b1;
    end else begin
      hs_out_q <= hsync_in;
      vs_out_q <= vsync_in;
      rgb_q    <= (ready_in && !black) ? sel_rgb : '0;
    end
  end

  assign rgb_out   = rgb_q;
  assign hsync_out = hs_out_q;
  assign vsync_out = vs_out_q;
  assign screen_id = screen_q;
  assign switching = switching_q;

endmodule

// File: tb/tb_screen_sched_ctrl.sv
// Scoreboard bench for screen_sched_ctrl on a shrunken 10x6 frame; blank-frame tests follow SCREEN_BLANK_EN.
module tb_screen_sched_ctrl;
  localparam int BF = 2;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hsync_in = 1'b1;
  logic         vsync_in = 1'b1;
  logic         ready_in = 1'b0;
  logic         start_req = 1'b0;
  logic         play_req = 1'b0;
  logic         over_req = 1'b0;
  logic [W-1:0] start_rgb = 8'hA5;
  logic [W-1:0] play_rgb = 8'h30;
  logic [W-1:0] over_rgb = 8'hC0;
  logic [W-1:0] rgb_out;
  logic         hsync_out;
  logic         vsync_out;
  logic [1:0]   screen_id;
  logic         switching;

  screen_sched_ctrl #(.BLANK_FRAMES(BF), .RGB_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .ready_in(ready_in), .start_req(start_req), .play_req(play_req),
    .over_req(over_req), .start_rgb(start_rgb), .play_rgb(play_rgb),
    .over_rgb(over_rgb), .rgb_out(rgb_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .screen_id(screen_id), .switching(switching)
  );

  // clock / reset
  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail = 0;
  int           h_cnt = 9;
  int           v_cnt = 5;
  logic         prev_vs = 1'b1;
  logic         is_fb = 1'b0;
  logic [W+1:0] stage = '0;
  logic         stage_v = 1'b0;
  logic         push_en = 1'b0;
  logic [1:0]   m_scr = 2'd0;
  logic         m_black = 1'b0;
  logic [W+1:0] exp_q[$];

  function automatic logic [W-1:0] exp_rgb();
    if (!ready_in || m_black) return '0;
    case (m_scr)
      2'd0:    return start_rgb;
      2'd1:    return play_rgb;
      default: return over_rgb;
    endcase
  endfunction

  // driver: expected output for the inputs driven now is queued at the edge that captures them
  task automatic tick_req(input logic s, input logic p, input logic o);
    @(posedge clk);
    if (stage_v) exp_q.push_back(stage);
    #1;
    h_cnt = (h_cnt == 9) ? 0 : h_cnt + 1;
    if (h_cnt == 0) v_cnt = (v_cnt == 5) ? 0 : v_cnt + 1;
    prev_vs   = vsync_in;
    hsync_in  = !(h_cnt >= 8);
    vsync_in  = (v_cnt != 0);
    ready_in  = (h_cnt < 6) && (v_cnt >= 1) && (v_cnt <= 4);
    play_rgb  = W'(8'h30 + h_cnt);
    over_rgb  = W'(8'hC0 + v_cnt);
    start_req = s;
    play_req  = p;
    over_req  = o;
    is_fb     = prev_vs && !vsync_in;
    stage     = {exp_rgb(), hsync_in, vsync_in};
    stage_v   = push_en;
  endtask

  task automatic tick();
    tick_req(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic to_fb();
    for (int k = 0; k < 200; k++) begin
      tick();
      if (is_fb) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL fb_timeout: got no frame boundary in 200 clk, required one");
  endtask

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // Blank frames (when built in) follow the first boundary, then the new screen shows.
  task automatic finish_switch(input logic [1:0] s);
    to_fb();
`ifdef SCREEN_BLANK_EN
    m_black = 1'b1;
    tick();
    chk("sw_in_blank", W'(switching), 8'd1);
    repeat (BF) to_fb();
    m_black = 1'b0;
`endif
    m_scr = s;
  endtask

  // monitor / scoreboard
  initial begin
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({rgb_out, hsync_out, vsync_out} !== e) begin
          n_fail++;
          $display("FAIL pix: got rgb=%h hs=%b vs=%b, required rgb=%h hs=%b vs=%b",
                   rgb_out, hsync_out, vsync_out, e[W+1:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    // reset and idle
    ticks(10);
    chk("rst_rgb", rgb_out, 8'h00);
    chk("rst_hs", W'(hsync_out), 8'd1);
    chk("rst_vs", W'(vsync_out), 8'd1);
    chk("rst_scr", W'(screen_id), 8'd0);
    chk("rst_sw", W'(switching), 8'd0);
    rst_n   = 1'b1;
    push_en = 1'b1;
    to_fb();
    to_fb();
    chk("idle_scr", W'(screen_id), 8'd0);
    chk("idle_sw", W'(switching), 8'd0);

    // single switch to play, requested mid-frame
    ticks(25);
    tick_req(1'b0, 1'b1, 1'b0);
    tick();
    chk("sw_rise", W'(switching), 8'd1);
    chk("scr_hold", W'(screen_id), 8'd0);
    finish_switch(2'd1);
    tick();
    chk("play_scr", W'(screen_id), 8'd1);
    chk("play_sw", W'(switching), 8'd0);
    ticks(30);

    // all three requests at once: over wins
    tick_req(1'b1, 1'b1, 1'b1);
    tick();
    chk("simul_sw", W'(switching), 8'd1);
    finish_switch(2'd2);
    tick();
    chk("simul_scr", W'(screen_id), 8'd2);
    ticks(20);

    // redundant request is ignored
    tick_req(1'b0, 1'b0, 1'b1);
    tick();
    chk("redund_sw", W'(switching), 8'd0);
    to_fb();
    tick();
    chk("redund_scr", W'(screen_id), 8'd2);
    chk("redund_sw2", W'(switching), 8'd0);
    ticks(20);

    // latest request wins while waiting for the boundary
    tick_req(1'b0, 1'b1, 1'b0);
    ticks(3);
    tick_req(1'b1, 1'b0, 1'b0);
    finish_switch(2'd0);
    tick();
    chk("ovr_scr", W'(screen_id), 8'd0);
    ticks(20);

`ifdef SCREEN_BLANK_EN
    // overrides during blanking; ending on the current screen still blanks fully
    tick_req(1'b0, 1'b0, 1'b1);
    to_fb();
    m_black = 1'b1;
    ticks(5);
    tick_req(1'b0, 1'b1, 1'b0);
    ticks(3);
    tick_req(1'b1, 1'b0, 1'b0);
    repeat (BF) to_fb();
    m_black = 1'b0;
    m_scr   = 2'd0;
    tick();
    chk("blank_ovr_scr", W'(screen_id), 8'd0);
    chk("blank_ovr_sw", W'(switching), 8'd0);
    ticks(20);
`endif

    // reset in the middle of a change
    tick_req(1'b0, 1'b0, 1'b1);
    ticks(5);
`ifdef SCREEN_BLANK_EN
    to_fb();
    m_black = 1'b1;
    ticks(10);
`endif
    push_en = 1'b0;
    stage_v = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scr", W'(screen_id), 8'd0);
    chk("mid_rst_sw", W'(switching), 8'd0);
    chk("mid_rst_rgb", rgb_out, 8'h00);
    ticks(3);
    rst_n   = 1'b1;
    m_black = 1'b0;
    m_scr   = 2'd0;
    push_en = 1'b1;
    to_fb();
    to_fb();
    tick();
    chk("post_rst_scr", W'(screen_id), 8'd0);
    chk("post_rst_sw", W'(switching), 8'd0);
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
